// File: rtl/gf180_sram_pkg.sv
// Shared types and helpers for the gf180 SRAM array model.
// Holds the clear/idle state encoding and the address-width helper.
package gf180_sram_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        IDLE  = 1'b1
    } state_t;

    function automatic int sram_aw(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/gf180_sram_clear_seq.sv
// Power-up / reset clear sequencer: walks every word once writing zeros,
// then raises ready. Owns the state machine and the clear counter.
module gf180_sram_clear_seq
    import gf180_sram_pkg::*;
#(
    parameter int DEPTH = 512,
    parameter int AW    = sram_aw(DEPTH)
) (
    input  logic          i_clk,
    input  logic          i_rst,
    output logic [AW-1:0] o_clr_addr,
    output logic          o_clr_we,
    output logic          o_ready
);

    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    state_t        r_state;
    logic [AW-1:0] r_clr_cnt;
    logic          r_ready;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= CLEAR;
            r_clr_cnt <= '0;
            r_ready   <= 1'b0;
        end else begin
            case (r_state)
                CLEAR: begin
                    // The write of the last word and the move to IDLE share one edge.
                    if (r_clr_cnt == LAST_ADDR) begin
                        r_state   <= IDLE;
                        r_clr_cnt <= '0;
                        r_ready   <= 1'b1;
                    end else begin
                        r_clr_cnt <= r_clr_cnt + 1'b1;
                    end
                end
                IDLE: begin
                    r_ready <= 1'b1;
                end
                default: begin
                    r_state <= CLEAR;
                    r_ready <= 1'b0;
                end
            endcase
        end
    end

    assign o_clr_addr = r_clr_cnt;
    assign o_clr_we   = (r_state == CLEAR);
    assign o_ready    = r_ready;

endmodule

// File: rtl/gf180_sram_array.sv
// Single-port SRAM array with bit-masked writes and a self-clearing reset.
// Define GF180_SRAM_ARRAY_OUTREG_EN for an extra output register (read latency 2).
module gf180_sram_array
    import gf180_sram_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 512
) (
    input  logic                        CLK,
    input  logic                        RST,
    input  logic                        CEN,
    input  logic                        GWEN,
    input  logic [WIDTH-1:0]            WEN,
    input  logic [sram_aw(DEPTH)-1:0]   A,
    input  logic [WIDTH-1:0]            D,
    output logic [WIDTH-1:0]            Q,
    output logic                        READY
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_q;
    logic [AW-1:0]    w_clr_addr;
    logic             w_clr_we;
    logic             w_ready;
    logic             w_in_range;
    logic             w_rd;
    logic             w_wr;
    logic [WIDTH-1:0] w_mask;

    gf180_sram_clear_seq #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_clear_seq (
        .i_clk      (CLK),
        .i_rst      (RST),
        .o_clr_addr (w_clr_addr),
        .o_clr_we   (w_clr_we),
        .o_ready    (w_ready)
    );

    assign w_in_range = ({1'b0, A} < (AW + 1)'(DEPTH));
    assign w_rd       = w_ready && !CEN && !GWEN;
    assign w_wr       = w_ready && !CEN && GWEN && w_in_range;
    assign w_mask     = ~WEN;

    // Storage carries no reset; the clear sequencer zeroes it word by word.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            if (w_clr_we) begin
                r_mem[w_clr_addr] <= '0;
            end else if (w_wr) begin
                r_mem[A] <= (r_mem[A] & ~w_mask) | (D & w_mask);
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_q <= '0;
        end else if (w_rd) begin
            r_q <= w_in_range ? r_mem[A] : '0;
        end
    end

`ifdef GF180_SRAM_ARRAY_OUTREG_EN
    logic             r_rd_d;
    logic [WIDTH-1:0] r_q2;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_rd_d <= 1'b0;
            r_q2   <= '0;
        end else begin
            r_rd_d <= w_rd;
            if (r_rd_d) begin
                r_q2 <= r_q;
            end
        end
    end

    assign Q = r_q2;
`else
    assign Q = r_q;
`endif

    assign READY = w_ready;

endmodule

// File: tb/tb_gf180_sram_array.sv
// Scoreboard bench for gf180_sram_array: a 512x8 instance and a 300x16 instance.
module tb_gf180_sram_array;

`ifdef GF180_SRAM_ARRAY_OUTREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    // 512 x 8 instance
    logic       rst1 = 1'b1, cen1 = 1'b1, gwen1 = 1'b0;
    logic [7:0] wen1 = 8'hFF, d1 = '0, q1;
    logic [8:0] a1 = '0;
    logic       ready1;

    // 300 x 16 instance
    logic        rst2 = 1'b1, cen2 = 1'b1, gwen2 = 1'b0;
    logic [15:0] wen2 = 16'hFFFF, d2 = '0, q2;
    logic [8:0]  a2 = '0;
    logic        ready2;

    gf180_sram_array #(.WIDTH(8), .DEPTH(512)) u_dut1 (
        .CLK(CLK), .RST(rst1), .CEN(cen1), .GWEN(gwen1), .WEN(wen1),
        .A(a1), .D(d1), .Q(q1), .READY(ready1)
    );

    gf180_sram_array #(.WIDTH(16), .DEPTH(300)) u_dut2 (
        .CLK(CLK), .RST(rst2), .CEN(cen2), .GWEN(gwen2), .WEN(wen2),
        .A(a2), .D(d2), .Q(q2), .READY(ready2)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboards: expectations pushed at issue, popped when read data emerges.
    logic [7:0]  exp_q1 [$];
    logic [15:0] exp_q2 [$];
    logic [1:0]  rd_pipe1 = '0;
    logic [1:0]  rd_pipe2 = '0;

    always @(posedge CLK) begin
        rd_pipe1 <= {rd_pipe1[0], (!rst1 && ready1 && !cen1 && !gwen1)};
        rd_pipe2 <= {rd_pipe2[0], (!rst2 && ready2 && !cen2 && !gwen2)};
    end

    always @(negedge CLK) begin
        if (rd_pipe1[LAT-1]) begin
            if (exp_q1.size() == 0) chk("q1_unexpected_read", 64'(q1), 64'hDEAD);
            else chk("q1_read", 64'(q1), 64'(exp_q1.pop_front()));
        end
        if (rd_pipe2[LAT-1]) begin
            if (exp_q2.size() == 0) chk("q2_unexpected_read", 64'(q2), 64'hDEAD);
            else chk("q2_read", 64'(q2), 64'(exp_q2.pop_front()));
        end
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic rd1(input logic [8:0] a, input logic [7:0] e);
        cen1 = 1'b0; gwen1 = 1'b0; a1 = a;
        exp_q1.push_back(e);
        step();
    endtask

    task automatic wr1(input logic [8:0] a, input logic [7:0] d, input logic [7:0] wen);
        cen1 = 1'b0; gwen1 = 1'b1; a1 = a; d1 = d; wen1 = wen;
        step();
    endtask

    task automatic rd2(input logic [8:0] a, input logic [15:0] e);
        cen2 = 1'b0; gwen2 = 1'b0; a2 = a;
        exp_q2.push_back(e);
        step();
    endtask

    task automatic wr2(input logic [8:0] a, input logic [15:0] d);
        cen2 = 1'b0; gwen2 = 1'b1; a2 = a; d2 = d; wen2 = '0;
        step();
    endtask

    task automatic drain();
        int n = 0;
        cen1 = 1'b1; cen2 = 1'b1;
        while ((exp_q1.size() != 0 || exp_q2.size() != 0) && n < 20) begin
            step();
            n++;
        end
        step();
        chk("scoreboard_drained", 64'(exp_q1.size() + exp_q2.size()), 64'd0);
    endtask

    task automatic wait_ready1(output int n);
        n = 0;
        while (!ready1 && n < 5000) begin
            step();
            n++;
        end
    endtask

    initial begin
        int n;

        // Reset state, with RST held for several edges
        repeat (3) step();
        chk("reset_ready1", 64'(ready1), 64'd0);
        chk("reset_q1", 64'(q1), 64'd0);
        chk("reset_ready2", 64'(ready2), 64'd0);
        chk("reset_q2", 64'(q2), 64'd0);

        // Clear timing with a write to 0x010 held during the clear
        rst2 = 1'b0;
        cen1 = 1'b0; gwen1 = 1'b1; a1 = 9'h010; d1 = 8'hFF; wen1 = 8'h00;
        rst1 = 1'b0;
        n = 0;
        while (!ready1 && n < 5000) begin
            step();
            n++;
            if (n == 400) cen1 = 1'b1;
        end
        chk("clear_cycles_512", 64'(n), 64'd512);
        step();
        chk("ready_stays_high", 64'(ready1), 64'd1);

        rd1(9'h010, 8'h00);
        for (int unsigned i = 0; i < 512; i++) rd1(9'(i), 8'h00);
        drain();

        // Masked write
        wr1(9'h005, 8'hFF, 8'hF0);
        rd1(9'h005, 8'h0F);
        drain();

        // Hold behaviour: CEN=1 with read-like inputs must not disturb Q
        wr1(9'h007, 8'hA5, 8'h00);
        rd1(9'h007, 8'hA5);
        cen1 = 1'b1; gwen1 = 1'b0; a1 = 9'h005;
        for (int unsigned i = 0; i < 10; i++) begin
            step();
            chk("hold_cen_high", 64'(q1), 64'hA5);
        end
        wr1(9'h007, 8'h00, 8'hFF);
        cen1 = 1'b1;
        step();
        chk("noop_write_q_hold", 64'(q1), 64'hA5);
        rd1(9'h005, 8'h0F);
        rd1(9'h007, 8'hA5);
        drain();

        // Reset mid-clear
        rst1 = 1'b1; step(); rst1 = 1'b0;
        repeat (200) step();
        chk("midclear_ready_low", 64'(ready1), 64'd0);
        rst1 = 1'b1; step(); rst1 = 1'b0;
        chk("midclear_q_reset", 64'(q1), 64'd0);
        wait_ready1(n);
        chk("midclear_cycles_512", 64'(n), 64'd512);
        rd1(9'h005, 8'h00);
        rd1(9'h007, 8'h00);
        drain();

        // Non-power-of-two depth instance (cleared in parallel earlier)
        n = 0;
        while (!ready2 && n < 5000) begin
            step();
            n++;
        end
        chk("dut2_ready", 64'(ready2), 64'd1);
        wr2(9'd299, 16'hBEEF);
        rd2(9'd299, 16'hBEEF);
        wr2(9'd310, 16'h1234);
        rd2(9'd310, 16'h0000);
        rd2(9'd299, 16'hBEEF);
        rd2(9'd0, 16'h0000);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule

// File: doc/gf180_sram_array.md
GF180_SRAM_ARRAY -- requirements
Module: gf180_sram_array

Interface
REQ-001 SHALL have parameter WIDTH, default 8: data word width in bits, range 1..64.
REQ-002 SHALL have parameter DEPTH, default 512: number of words, range 2..4096, need not be a power of two.
REQ-003 SHALL have localparam AW = $clog2(DEPTH): the address width.
REQ-004 SHALL have port CLK, input, 1 bit: the single clock; all logic on its rising edge.
REQ-005 SHALL have port RST, input, 1 bit: reset, synchronous, active-high.
REQ-006 SHALL have port CEN, input, 1 bit: chip enable, active-low.
REQ-007 SHALL have port GWEN, input, 1 bit: 0 = read, 1 = masked write.
REQ-008 SHALL have port WEN, input, WIDTH bits: per-bit write enable, active-low.
REQ-009 SHALL have port A, input, AW bits: word address.
REQ-010 SHALL have port D, input, WIDTH bits: write data.
REQ-011 SHALL have port Q, output, WIDTH bits: registered read data.
REQ-012 SHALL have port READY, output, 1 bit: high when the array accepts accesses.

Function
REQ-013 SHALL implement a two-state FSM: CLEAR and IDLE.
REQ-014 SHALL, in CLEAR, write all-zero data to address clr_cnt each cycle and increment clr_cnt from 0.
REQ-015 SHALL go from CLEAR to IDLE on the cycle that writes address DEPTH-1, so the clear takes exactly DEPTH cycles.
REQ-016 SHALL drive READY low in CLEAR and high in IDLE; READY rises on the cycle after the last clear write.
REQ-017 SHALL ignore CEN, GWEN, WEN, A and D in CLEAR, and hold Q during CLEAR.
REQ-018 SHALL treat an access in IDLE as active only when CEN=0.
REQ-019 SHALL, on an active read (GWEN=0), load Q with mem[A] at the next edge (latency 1); memory is unchanged.
REQ-020 SHALL, on an active write (GWEN=1), set mem[A][i] = D[i] for every bit i where WEN[i]=0, leave all other bits unchanged, and hold Q.
REQ-021 SHALL treat an active write with WEN all ones as a no-op.
REQ-022 SHALL hold Q at its last value when CEN=1 (no read).
REQ-023 SHALL, for A >= DEPTH, ignore writes and load Q with 0 on reads.
REQ-024 SHALL hold the read address value (no read-during-write case): GWEN selects exactly one operation per cycle.

Reset
REQ-025 SHALL, on RST=1 at a rising edge, enter CLEAR with clr_cnt=0, Q=0 and READY=0, regardless of current state.
REQ-026 SHALL restart the clear from address 0 when RST is asserted mid-CLEAR, still taking the full DEPTH cycles.
REQ-027 SHALL begin clearing on the first edge after RST deasserts; RST held high keeps the block in CLEAR at clr_cnt=0.

Configuration
REQ-028 SHALL use macro GF180_SRAM_ARRAY_OUTREG_EN to enable the output pipeline stage.
REQ-029 SHALL, when GF180_SRAM_ARRAY_OUTREG_EN is defined, add one extra output register stage: read latency 2, both stages reset to 0, and the stage holds its value on non-read cycles exactly like Q.
REQ-030 SHALL, when GF180_SRAM_ARRAY_OUTREG_EN is undefined, have read latency 1 per REQ-019.
REQ-031 SHALL have READY timing independent of GF180_SRAM_ARRAY_OUTREG_EN.

Structure
REQ-032 SHALL have shared package gf180_sram_pkg holding the FSM state enum (CLEAR, IDLE) and the address-width helper function.
REQ-033 SHALL have one sub-module, gf180_sram_clear_seq, containing the FSM and clr_cnt and driving the clear address, the clear write strobe and READY.
REQ-034 SHALL keep the storage array and the read/write muxing in gf180_sram_array.

Verification
REQ-035 SHALL verify clear timing: DEPTH=512, pulse RST for 1 cycle -> READY low for exactly 512 cycles, then high; every address then reads 0x00.
REQ-036 SHALL verify masked write: write A=0x005, D=0xFF, WEN=0xF0, then read A=0x005 -> Q=0x0F one cycle after the read (two cycles if OUTREG_EN).
REQ-037 SHALL verify access blocking during clear: attempt a write at A=0x010 during CLEAR -> after READY, reading A=0x010 returns 0x00.
REQ-038 SHALL verify reset mid-clear: assert RST at clear cycle 200 -> READY stays low for a further full 512 cycles after RST deasserts.
REQ-039 SHALL verify non-power-of-two depth: DEPTH=300, WIDTH=16; write A=310 then read A=310 -> Q=0x0000; A=299 write/read of 0xBEEF -> Q=0xBEEF.
REQ-040 SHALL verify hold behaviour: CEN=1 for 10 cycles after a read of 0xA5 -> Q stays 0xA5; a write with WEN=0xFF changes neither memory nor Q.
